// File: rtl/pulse_pkg.sv
// pulse_pkg: field widths and state encoding shared by the pulse generator and pulse_capture
package pulse_pkg;
  localparam int DELAY_W = 16;
  localparam int WIDTH_W = 8;
  localparam int COUNT_W = 8;
  localparam int SPACING_W = 16;
  typedef enum logic [2:0] {IDLE, ARMED, WAIT_EDGE, HIGH, LOW, DONE} state_t;
  function automatic logic [SPACING_W-1:0] eff_timeout(input logic [SPACING_W-1:0] t);
    return (t == '0) ? SPACING_W'(1) : t;
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: optional synchroniser chain plus one-cycle history giving level, rise and fall
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_i,
  output logic p,
  output logic rise,
  output logic fall
);
  logic p_d;
  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign p = pulse_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge clk) chain <= rst ? '0 : SYNC_STAGES'({chain, pulse_i});
      assign p = chain[SYNC_STAGES-1];
    end
  endgenerate
  always_ff @(posedge clk) p_d <= rst ? 1'b0 : p;
  assign rise = p & ~p_d;
  assign fall = ~p & p_d;
endmodule

// File: rtl/pulse_capture.sv
// pulse_capture: measures delay, first width, count and first spacing of a pulse train
module pulse_capture
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm_i,
  input  logic                 start_i,
  input  logic                 pulse_i,
  input  logic [SPACING_W-1:0] timeout_i,
  output logic [DELAY_W-1:0]   delay_o,
  output logic [WIDTH_W-1:0]   width_o,
  output logic [COUNT_W-1:0]   count_o,
  output logic [SPACING_W-1:0] spacing_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 valid_o,
  output logic                 overflow_o
);
  state_t state, state_n;
  logic p, rise, fall;
  logic [DELAY_W-1:0] dcnt, dcnt_inc;
  logic [WIDTH_W-1:0] wcnt;
  logic [SPACING_W-1:0] gcnt, tmo;
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .pulse_i(pulse_i), .p(p), .rise(rise), .fall(fall)
  );
  assign dcnt_inc = dcnt + 1'b1;
  assign tmo = eff_timeout(timeout_i);
  assign busy_o = state inside {ARMED, WAIT_EDGE, HIGH, LOW};
  assign valid_o = state == DONE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = arm_i ? ARMED : state;
      ARMED:      state_n = (start_i && !arm_i) ? WAIT_EDGE : ARMED;
      WAIT_EDGE:  state_n = rise ? HIGH : (dcnt_inc == '1) ? DONE : WAIT_EDGE;
      HIGH:       state_n = fall ? LOW : HIGH;
      LOW:        state_n = rise ? HIGH : (!p && gcnt == tmo) ? DONE : LOW;
      default:    state_n = IDLE;
    endcase
  end
  // a rise always beats the timeout; the first pulse alone feeds width and spacing
  always_ff @(posedge clk) begin
    if (rst) begin
      {delay_o, width_o, count_o, spacing_o, overflow_o, done_o} <= '0;
      {dcnt, wcnt, gcnt} <= '0;
    end else begin
      done_o <= (state_n == DONE) && (state != DONE);
      case (state)
        IDLE, DONE: if (arm_i) {delay_o, width_o, count_o, spacing_o, overflow_o} <= '0;
        ARMED: dcnt <= '0;
        WAIT_EDGE: begin
          dcnt <= dcnt_inc;
          if (rise) begin
            delay_o <= dcnt_inc;
            count_o <= COUNT_W'(1);
            wcnt <= WIDTH_W'(1);
          end else if (dcnt_inc == '1) begin
            delay_o <= '1;
            overflow_o <= 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            if (count_o == COUNT_W'(1)) width_o <= wcnt;
            gcnt <= SPACING_W'(1);
          end else if (count_o == COUNT_W'(1)) begin
            if (&wcnt) overflow_o <= 1'b1;
            else wcnt <= wcnt + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            if (&count_o) overflow_o <= 1'b1;
            else count_o <= count_o + 1'b1;
            if (count_o == COUNT_W'(1)) spacing_o <= gcnt;
          end else if (~&gcnt) gcnt <= gcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: directed pulse trains checked cycle by cycle against a train-level model
module tb_pulse_capture;
  logic clk = 0, rst = 1, arm_i = 0, start_i = 0, pulse_i = 0;
  logic [15:0] timeout_i = 16'd1;
  logic [15:0] delay_o, spacing_o;
  logic [7:0] width_o, count_o;
  logic busy_o, done_o, valid_o, overflow_o;
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  logic chk_en = 0;
  int k_q;
  int hi_q[$], lo_q[$];
  int e_delay, e_width, e_count, e_spacing, e_done;
  logic e_ovf;

  pulse_capture #(.SYNC_STAGES(0)) dut (
    .clk(clk), .rst(rst), .arm_i(arm_i), .start_i(start_i), .pulse_i(pulse_i),
    .timeout_i(timeout_i), .delay_o(delay_o), .width_o(width_o), .count_o(count_o),
    .spacing_o(spacing_o), .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // pulse level in cycle t after the start cycle (t=0), from delay/high/low lists
  function automatic logic level(input int t);
    int pos;
    if (t < k_q) return 1'b0;
    pos = k_q;
    for (int i = 0; i < hi_q.size(); i++) begin
      if (t < pos + hi_q[i]) return 1'b1;
      pos += hi_q[i];
      if (i < lo_q.size()) begin
        if (t < pos + lo_q[i]) return 1'b0;
        pos += lo_q[i];
      end
    end
    return 1'b0;
  endfunction

  // train-level rules: a gap no longer than the timeout continues the train
  task automatic model(input int tmo);
    int te, n, r, f;
    te = (tmo == 0) ? 1 : tmo;
    if (hi_q.size() == 0 || k_q > 65535) begin
      e_delay = 65535; e_width = 0; e_count = 0; e_spacing = 0; e_ovf = 1; e_done = 65536;
      return;
    end
    e_delay = k_q;
    e_width = (hi_q[0] > 255) ? 255 : hi_q[0];
    e_ovf = hi_q[0] > 255;
    e_spacing = 0;
    n = 1;
    r = k_q;
    for (int i = 0; i < hi_q.size(); i++) begin
      f = r + hi_q[i];
      if (i < lo_q.size() && i + 1 < hi_q.size() && lo_q[i] <= te) begin
        if (i == 0) e_spacing = lo_q[0];
        n++;
        r = f + lo_q[i];
      end else begin
        e_done = f + te + 1;
        break;
      end
    end
    e_count = (n > 255) ? 255 : n;
    if (n > 255) e_ovf = 1;
  endtask

  task automatic run_train(input int k, input int tmo);
    k_q = k;
    model(tmo);
    step();
    arm_i = 1; timeout_i = 16'(tmo); pulse_i = 0;
    step();
    arm_i = 0; start_i = 1; cyc = 0; pulse_i = level(0); chk_en = 1;
    for (int t = 1; t <= e_done + 2; t++) begin
      step();
      start_i = 0; cyc = t; pulse_i = level(t);
    end
    chk_en = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic ok;
      ok = (busy_o == (cyc < e_done)) && (valid_o == (cyc >= e_done)) && (done_o == (cyc == e_done));
      if (cyc == 0) ok = ok && ({delay_o, width_o, count_o, spacing_o, overflow_o} == '0);
      if (cyc >= e_done)
        ok = ok && delay_o == 16'(e_delay) && width_o == 8'(e_width) && count_o == 8'(e_count)
             && spacing_o == 16'(e_spacing) && overflow_o == e_ovf;
      n_cmp++;
      if (!ok) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL train cyc=%0d got busy=%b valid=%b done=%b delay=%0d width=%0d count=%0d spacing=%0d ovf=%b want done_cyc=%0d delay=%0d width=%0d count=%0d spacing=%0d ovf=%b",
                   cyc, busy_o, valid_o, done_o, delay_o, width_o, count_o, spacing_o, overflow_o,
                   e_done, e_delay, e_width, e_count, e_spacing, e_ovf);
      end
    end
  end

  initial begin
    int seen;
    step(); step();
    @(negedge clk);
    lit("reset_outputs", {delay_o, width_o, count_o, spacing_o, busy_o, done_o, valid_o, overflow_o}, 0);
    rst = 0;
    // rise one cycle after start
    hi_q = '{3}; lo_q = '{};
    run_train(1, 4);
    lit("m1_done", e_done, 9);
    lit("s1_delay", delay_o, 1);
    lit("s1_width", width_o, 3);
    // three-pulse train, result held until re-armed
    hi_q = '{2, 2, 2}; lo_q = '{8, 8};
    run_train(5, 10);
    lit("m2_done", e_done, 38);
    for (int i = 0; i < 20; i++) step();
    @(negedge clk);
    lit("s2_count", count_o, 3);
    lit("s2_spacing", spacing_o, 8);
    lit("s2_valid_held", valid_o, 1);
    // arm and start together: start ignored, pulse must not be measured
    step(); arm_i = 1; start_i = 1; timeout_i = 16'd1;
    step(); arm_i = 0; start_i = 0; pulse_i = 1;
    for (int i = 0; i < 3; i++) step();
    pulse_i = 0;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    lit("armstart_busy_valid_count", {busy_o, valid_o, count_o}, 10'b10_0000_0000);
    step(); rst = 1;
    step(); rst = 0;
    // reset while HIGH aborts without done_o
    step(); arm_i = 1;
    step(); arm_i = 0; start_i = 1;
    step(); start_i = 0;
    step(); pulse_i = 1;
    step(); step(); rst = 1;
    step(); rst = 0;
    @(negedge clk);
    lit("rst_in_high", {delay_o, width_o, count_o, spacing_o, busy_o, done_o, valid_o, overflow_o}, 0);
    seen = 0;
    pulse_i = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o) seen++;
    end
    lit("rst_no_done", seen, 0);
    // level already high at start is not an edge
    step(); arm_i = 1; pulse_i = 1; timeout_i = 16'd20;
    step(); arm_i = 0; start_i = 1;
    for (int t = 1; t <= 40; t++) begin
      step();
      start_i = 0;
      pulse_i = (t <= 5) || (t == 9) || (t == 10);
    end
    @(negedge clk);
    lit("prehigh_delay", delay_o, 9);
    lit("prehigh_width", width_o, 2);
    lit("prehigh_count_valid", {count_o, valid_o}, 9'b0000_0001_1);
    // width saturation
    hi_q = '{300}; lo_q = '{};
    run_train(3, 2);
    lit("s3_width", width_o, 255);
    lit("s3_ovf", overflow_o, 1);
    // timeout_i=0: gap of 1 continues, gap of 2 ends
    hi_q = '{2, 1, 1}; lo_q = '{1, 2};
    run_train(2, 0);
    lit("s4_count", count_o, 2);
    // gap equal to timeout continues, one longer ends
    hi_q = '{1, 1, 1}; lo_q = '{5, 6};
    run_train(4, 5);
    lit("s5_spacing", spacing_o, 5);
    // count saturation
    hi_q = '{}; lo_q = '{};
    for (int i = 0; i < 257; i++) begin
      hi_q.push_back(1);
      if (i < 256) lo_q.push_back(1);
    end
    run_train(2, 1);
    lit("s6_count", count_o, 255);
    // no pulse at all
    hi_q = '{}; lo_q = '{};
    run_train(70000, 3);
    lit("s7_count_ovf", {count_o, overflow_o}, 9'b0000_0000_1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
